// File: rtl/tartaruga_pkg.sv
// rtl/tartaruga_pkg.sv - shared datapath types and the default fetch queue depth.
package tartaruga_pkg;

  typedef logic [31:0] bus32_t;
  typedef logic [31:0] instruction_t;

  typedef struct packed {
    bus32_t       pc;
    instruction_t instr;
  } fetch_entry_t;

  localparam int unsigned FETCH_QUEUE_DEPTH = 4;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - fetch-to-decode instruction buffer with flush on taken branch.
// Optional same-cycle fetch-to-decode bypass when FETCH_QUEUE_BYPASS_EN is defined.
module fetch_queue
  import tartaruga_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_QUEUE_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     fetch_valid_i,
  input  bus32_t                   fetch_pc_i,
  input  instruction_t             fetch_instr_i,
  output logic                     fetch_ready_o,
  output logic                     decode_valid_o,
  output bus32_t                   decode_pc_o,
  output instruction_t             decode_instr_o,
  input  logic                     decode_ready_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  fetch_entry_t    mem_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic            empty;
  logic            bypass;
  logic            push;
  logic            pop;
  fetch_entry_t    head;

  assign empty         = (count_q == '0);
  assign fetch_ready_o = (count_q != FULL_COUNT);

`ifdef FETCH_QUEUE_BYPASS_EN
  // Reset is folded in so decode never sees a bypassed entry while reset is held.
  assign bypass = empty & fetch_valid_i & ~flush_i & ~rst_i;
`else
  assign bypass = 1'b0;
`endif

  assign pop  = ~empty & decode_ready_i & ~flush_i;
  assign push = fetch_valid_i & fetch_ready_o & ~flush_i & ~(bypass & decode_ready_i);

  assign head           = mem_q[rd_ptr_q];
  assign decode_valid_o = ~empty | bypass;
  assign decode_pc_o    = bypass ? fetch_pc_i    : head.pc;
  assign decode_instr_o = bypass ? fetch_instr_i : head.instr;
  assign count_o        = count_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= '{pc: fetch_pc_i, instr: fetch_instr_i};
      end
    end
  end

endmodule
